// File: rtl/core_status.sv
// -----------------------------------------------------------------------------
// core_status
//
// Processor status (P) register and interrupt-poll stage of the CPU core.
// Sits directly downstream of the ALU: it commits the ALU carry/overflow/
// sign/zero results, executes the flag instructions (CLC/SEC/CLI/SEI/CLV/
// CLD/SED), takes whole-P loads for PLP/RTI, and feeds the stored flags back
// to the ALU. It also synchronises the NMI/IRQ pins and makes the
// per-instruction interrupt decision for the sequencer.
//
// Ports
//   I_clock          core clock, all state changes on the rising edge
//   I_reset_n        asynchronous active-low reset
//   I_ready          cycle enable; low freezes P, i_mask and the poll outputs
//   I_alu_write      commit ALU flags into N, V, Z, C
//   I_alu_carry / I_alu_overflow / I_alu_sign / I_alu_zero   ALU flag results
//   I_p_load         load P from I_data (PLP, RTI pull)
//   I_data[7:0]      pulled status byte
//   I_flag_op[2:0]   0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED
//   I_set_i          force I = 1 (interrupt / BRK entry)
//   I_push_brk       value placed on bit 4 of O_push
//   I_sync           opcode-fetch cycle (instruction boundary)
//   I_int_ack        sequencer has started interrupt entry
//   I_nmi_n, I_irq_n asynchronous active-low interrupt pins
//   O_p[7:0]         stored P with bit 5 = 1, bit 4 = 0
//   O_push[7:0]      stored P with bit 5 = 1, bit 4 = I_push_brk
//   O_carry / O_overflow / O_sign / O_zero   stored C, V, N, Z to the ALU
//   O_int_req        take an interrupt instead of the next opcode
//   O_int_nmi        the pending request is an NMI (valid with O_int_req)
// -----------------------------------------------------------------------------
module core_status #(
  parameter logic [7:0] P_RESET = 8'h24
) (
  input  logic       I_clock,
  input  logic       I_reset_n,
  input  logic       I_ready,
  input  logic       I_alu_write,
  input  logic       I_alu_carry,
  input  logic       I_alu_overflow,
  input  logic       I_alu_sign,
  input  logic       I_alu_zero,
  input  logic       I_p_load,
  input  logic [7:0] I_data,
  input  logic [2:0] I_flag_op,
  input  logic       I_set_i,
  input  logic       I_push_brk,
  input  logic       I_sync,
  input  logic       I_int_ack,
  input  logic       I_nmi_n,
  input  logic       I_irq_n,
  output logic [7:0] O_p,
  output logic [7:0] O_push,
  output logic       O_carry,
  output logic       O_overflow,
  output logic       O_sign,
  output logic       O_zero,
  output logic       O_int_req,
  output logic       O_int_nmi
);

  // Flag-instruction encodings on I_flag_op.
  localparam logic [2:0] FLAG_NONE = 3'd0;
  localparam logic [2:0] FLAG_CLC  = 3'd1;
  localparam logic [2:0] FLAG_SEC  = 3'd2;
  localparam logic [2:0] FLAG_CLI  = 3'd3;
  localparam logic [2:0] FLAG_SEI  = 3'd4;
  localparam logic [2:0] FLAG_CLV  = 3'd5;
  localparam logic [2:0] FLAG_CLD  = 3'd6;
  localparam logic [2:0] FLAG_SED  = 3'd7;

  // Stored status bits. Bits 5 and 4 of P have no storage.
  logic n_r, v_r, d_r, i_r, z_r, c_r;

  // Next-state values for the stored bits.
  logic n_next_s, v_next_s, d_next_s, i_src_s, i_next_s, z_next_s, c_next_s;

  // IRQ mask as seen by the poll: lags stored I by one instruction.
  logic i_mask_r;

  // Interrupt pin synchronisers and NMI edge detection.
  logic nmi_sync1_r, nmi_sync2_r, nmi_prev_r, nmi_pending_r;
  logic irq_sync1_r, irq_sync2_r;
  logic nmi_edge_s;

  // Poll results.
  logic int_req_r, int_nmi_r;

  // Qualified control strobes.
  logic poll_s, ack_s;

  // Bits 5 and 4 of a pulled status byte are discarded.
  logic unused_data_s;
  assign unused_data_s = ^I_data[5:4];

  assign poll_s     = I_ready & I_sync;
  assign ack_s      = I_ready & I_int_ack;
  // Falling edge on the synchronised NMI line.
  assign nmi_edge_s = nmi_prev_r & ~nmi_sync2_r;

  // Next P: p_load beats everything, a flag op beats the ALU bit-by-bit,
  // and I_set_i beats every other source of I.
  always_comb begin
    n_next_s = n_r;
    v_next_s = v_r;
    d_next_s = d_r;
    i_src_s  = i_r;
    z_next_s = z_r;
    c_next_s = c_r;
    if (I_p_load) begin
      n_next_s = I_data[7];
      v_next_s = I_data[6];
      d_next_s = I_data[3];
      i_src_s  = I_data[2];
      z_next_s = I_data[1];
      c_next_s = I_data[0];
    end else begin
      if (I_alu_write) begin
        n_next_s = I_alu_sign;
        v_next_s = I_alu_overflow;
        z_next_s = I_alu_zero;
        c_next_s = I_alu_carry;
      end else begin
        n_next_s = n_r;
        v_next_s = v_r;
        z_next_s = z_r;
        c_next_s = c_r;
      end
      case (I_flag_op)
        FLAG_NONE: begin end
        FLAG_CLC:  c_next_s = 1'b0;
        FLAG_SEC:  c_next_s = 1'b1;
        FLAG_CLI:  i_src_s  = 1'b0;
        FLAG_SEI:  i_src_s  = 1'b1;
        FLAG_CLV:  v_next_s = 1'b0;
        FLAG_CLD:  d_next_s = 1'b0;
        FLAG_SED:  d_next_s = 1'b1;
        default:   begin end
      endcase
    end
    i_next_s = I_set_i ? 1'b1 : i_src_s;
  end

  // Status register: updates only on enabled cycles.
  always_ff @(posedge I_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      n_r <= P_RESET[7];
      v_r <= P_RESET[6];
      d_r <= P_RESET[3];
      i_r <= P_RESET[2];
      z_r <= P_RESET[1];
      c_r <= P_RESET[0];
    end else if (I_ready) begin
      n_r <= n_next_s;
      v_r <= v_next_s;
      d_r <= d_next_s;
      i_r <= i_next_s;
      z_r <= z_next_s;
      c_r <= c_next_s;
    end
  end

  // IRQ mask snapshot taken at each instruction boundary; the poll on that
  // same edge still sees the previous snapshot, which gives the one
  // instruction delay of CLI/SEI/PLP on IRQ masking.
  always_ff @(posedge I_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      i_mask_r <= 1'b1;
    end else if (poll_s) begin
      i_mask_r <= i_r;
    end
  end

  // Pin synchronisers and NMI previous-value flop; free-running so that NMI
  // edges during stalls are still seen.
  always_ff @(posedge I_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      nmi_sync1_r <= 1'b1;
      nmi_sync2_r <= 1'b1;
      nmi_prev_r  <= 1'b1;
      irq_sync1_r <= 1'b1;
      irq_sync2_r <= 1'b1;
    end else begin
      nmi_sync1_r <= I_nmi_n;
      nmi_sync2_r <= nmi_sync1_r;
      nmi_prev_r  <= nmi_sync2_r;
      irq_sync1_r <= I_irq_n;
      irq_sync2_r <= irq_sync1_r;
    end
  end

  // NMI pending latch: a new edge always wins over an acknowledge that
  // lands on the same clock.
  always_ff @(posedge I_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      nmi_pending_r <= 1'b0;
    end else if (nmi_edge_s) begin
      nmi_pending_r <= 1'b1;
    end else if (ack_s && int_nmi_r) begin
      nmi_pending_r <= 1'b0;
    end
  end

  // Poll outputs: sampled at the instruction boundary, held until the next
  // boundary or until the sequencer acknowledges entry.
  always_ff @(posedge I_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      int_req_r <= 1'b0;
      int_nmi_r <= 1'b0;
    end else if (ack_s) begin
      int_req_r <= 1'b0;
      int_nmi_r <= 1'b0;
    end else if (poll_s) begin
      int_req_r <= nmi_pending_r | (~irq_sync2_r & ~i_mask_r);
      int_nmi_r <= nmi_pending_r;
    end
  end

  // Outputs come straight from stored state; same-cycle writes are never
  // bypassed.
  assign O_p        = {n_r, v_r, 1'b1, 1'b0,       d_r, i_r, z_r, c_r};
  assign O_push     = {n_r, v_r, 1'b1, I_push_brk, d_r, i_r, z_r, c_r};
  assign O_carry    = c_r;
  assign O_overflow = v_r;
  assign O_sign     = n_r;
  assign O_zero     = z_r;
  assign O_int_req  = int_req_r;
  assign O_int_nmi  = int_nmi_r;

endmodule

// File: tb/tb_core_status.sv
// -----------------------------------------------------------------------------
// tb_core_status
//
// Directed bench for core_status. Inputs change 1 time unit after a rising
// edge and outputs are checked at that same point, so each check sees the
// state produced by the edge just taken.
// -----------------------------------------------------------------------------
module tb_core_status;

  logic       I_clock;
  logic       I_reset_n;
  logic       I_ready;
  logic       I_alu_write;
  logic       I_alu_carry;
  logic       I_alu_overflow;
  logic       I_alu_sign;
  logic       I_alu_zero;
  logic       I_p_load;
  logic [7:0] I_data;
  logic [2:0] I_flag_op;
  logic       I_set_i;
  logic       I_push_brk;
  logic       I_sync;
  logic       I_int_ack;
  logic       I_nmi_n;
  logic       I_irq_n;
  logic [7:0] O_p;
  logic [7:0] O_push;
  logic       O_carry;
  logic       O_overflow;
  logic       O_sign;
  logic       O_zero;
  logic       O_int_req;
  logic       O_int_nmi;

  int n_checks;
  int n_pass;

  core_status dut (
    .I_clock        (I_clock),
    .I_reset_n      (I_reset_n),
    .I_ready        (I_ready),
    .I_alu_write    (I_alu_write),
    .I_alu_carry    (I_alu_carry),
    .I_alu_overflow (I_alu_overflow),
    .I_alu_sign     (I_alu_sign),
    .I_alu_zero     (I_alu_zero),
    .I_p_load       (I_p_load),
    .I_data         (I_data),
    .I_flag_op      (I_flag_op),
    .I_set_i        (I_set_i),
    .I_push_brk     (I_push_brk),
    .I_sync         (I_sync),
    .I_int_ack      (I_int_ack),
    .I_nmi_n        (I_nmi_n),
    .I_irq_n        (I_irq_n),
    .O_p            (O_p),
    .O_push         (O_push),
    .O_carry        (O_carry),
    .O_overflow     (O_overflow),
    .O_sign         (O_sign),
    .O_zero         (O_zero),
    .O_int_req      (O_int_req),
    .O_int_nmi      (O_int_nmi)
  );

  initial begin
    I_clock = 1'b0;
    forever #5 I_clock = ~I_clock;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks = n_checks + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge I_clock);
    #1;
  endtask

  task automatic alu(input logic c, input logic v, input logic n, input logic z);
    I_alu_write    = 1'b1;
    I_alu_carry    = c;
    I_alu_overflow = v;
    I_alu_sign     = n;
    I_alu_zero     = z;
  endtask

  task automatic idle();
    I_ready     = 1'b1;
    I_alu_write = 1'b0;
    I_p_load    = 1'b0;
    I_flag_op   = 3'd0;
    I_set_i     = 1'b0;
    I_sync      = 1'b0;
    I_int_ack   = 1'b0;
  endtask

  task automatic plp(input logic [7:0] b);
    I_p_load = 1'b1;
    I_data   = b;
    step(1);
    I_p_load = 1'b0;
  endtask

  task automatic flag(input logic [2:0] op);
    I_flag_op = op;
    step(1);
    I_flag_op = 3'd0;
  endtask

  task automatic poll();
    I_sync = 1'b1;
    step(1);
    I_sync = 1'b0;
  endtask

  task automatic ack();
    I_int_ack = 1'b1;
    step(1);
    I_int_ack = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    I_reset_n      = 1'b0;
    I_alu_carry    = 1'b0;
    I_alu_overflow = 1'b0;
    I_alu_sign     = 1'b0;
    I_alu_zero     = 1'b0;
    I_data         = 8'h00;
    I_push_brk     = 1'b0;
    I_nmi_n        = 1'b1;
    I_irq_n        = 1'b1;
    idle();

    // Reset state.
    #12;
    check("rst_p",    O_p,       8'h24);
    check("rst_push", O_push,    8'h24);
    check("rst_req",  {7'd0, O_int_req}, 8'h00);
    check("rst_nmi",  {7'd0, O_int_nmi}, 8'h00);
    #10;
    I_reset_n = 1'b1;
    step(1);
    check("rel_p",   O_p,       8'h24);
    check("rel_req", {7'd0, O_int_req}, 8'h00);

    // PLP of FF: bits 5/4 forced to 1/0; push carries the BRK bit.
    plp(8'hFF);
    check("plp_ff", O_p, 8'hEF);
    I_push_brk = 1'b1;
    #1;
    check("push_brk", O_push, 8'hFF);
    I_push_brk = 1'b0;
    #1;
    check("push_nobrk", O_push, 8'hEF);

    // ALU commit and flag-op precedence.
    plp(8'h24);
    check("plp_24", O_p, 8'h24);
    alu(1'b1, 1'b1, 1'b0, 1'b1);
    step(1);
    I_alu_write = 1'b0;
    check("alu_67", O_p, 8'h67);
    check("alu_flags", {4'd0, O_sign, O_overflow, O_zero, O_carry}, 8'h07);
    alu(1'b1, 1'b1, 1'b0, 1'b1);
    flag(3'd1);
    I_alu_write = 1'b0;
    check("alu_clc", O_p, 8'h66);
    alu(1'b0, 1'b0, 1'b1, 1'b0);
    flag(3'd2);
    I_alu_write = 1'b0;
    check("alu_sec", O_p, 8'hA5);
    flag(3'd7);
    check("sed", O_p, 8'hAD);
    flag(3'd6);
    check("cld", O_p, 8'hA5);
    flag(3'd3);
    check("cli", O_p, 8'hA1);
    I_set_i = 1'b1;
    flag(3'd3);
    I_set_i = 1'b0;
    check("seti_over_cli", O_p, 8'hA5);
    alu(1'b1, 1'b1, 1'b1, 1'b1);
    I_flag_op = 3'd2;
    plp(8'h00);
    I_flag_op   = 3'd0;
    I_alu_write = 1'b0;
    check("pload_wins", O_p, 8'h20);

    // IRQ with the one-instruction CLI delay.
    plp(8'h66);
    poll();
    check("irq_idle", {7'd0, O_int_req}, 8'h00);
    I_irq_n = 1'b0;
    step(3);
    flag(3'd3);
    check("irq_cli_p", O_p, 8'h62);
    poll();
    check("irq_masked_old", {7'd0, O_int_req}, 8'h00);
    poll();
    check("irq_req", {6'd0, O_int_req, O_int_nmi}, 8'h02);
    ack();
    check("irq_ack", {6'd0, O_int_req, O_int_nmi}, 8'h00);
    I_irq_n = 1'b1;
    flag(3'd4);
    poll();
    step(3);

    // NMI: edge detected, one request per falling edge.
    I_nmi_n = 1'b0;
    step(2);
    I_sync = 1'b1;
    step(1);
    check("nmi_early", {7'd0, O_int_req}, 8'h00);
    step(1);
    I_sync = 1'b0;
    check("nmi_req", {6'd0, O_int_req, O_int_nmi}, 8'h03);
    ack();
    check("nmi_ack", {6'd0, O_int_req, O_int_nmi}, 8'h00);
    poll();
    check("nmi_held", {7'd0, O_int_req}, 8'h00);
    I_nmi_n = 1'b1;
    step(3);
    I_nmi_n = 1'b0;
    step(3);
    poll();
    check("nmi_again", {6'd0, O_int_req, O_int_nmi}, 8'h03);
    ack();

    // Stall: P and poll frozen, NMI edge still captured.
    I_nmi_n = 1'b1;
    step(3);
    flag(3'd3);
    check("stall_pre", O_p, 8'h62);
    I_ready   = 1'b0;
    I_sync    = 1'b1;
    I_flag_op = 3'd4;
    alu(1'b1, 1'b1, 1'b1, 1'b1);
    I_nmi_n   = 1'b0;
    step(10);
    check("stall_p", O_p, 8'h62);
    check("stall_req", {7'd0, O_int_req}, 8'h00);
    idle();
    I_sync = 1'b1;
    step(1);
    I_sync = 1'b0;
    check("stall_nmi", {6'd0, O_int_req, O_int_nmi}, 8'h03);
    check("stall_p_after", O_p, 8'h62);

    // Acknowledge coinciding with a new NMI edge keeps the NMI pending.
    I_nmi_n = 1'b1;
    step(3);
    I_nmi_n = 1'b0;
    step(2);
    ack();
    check("ack_edge_clr", {6'd0, O_int_req, O_int_nmi}, 8'h00);
    poll();
    check("ack_edge_keep", {6'd0, O_int_req, O_int_nmi}, 8'h03);
    ack();
    poll();
    check("ack_clears", {7'd0, O_int_req}, 8'h00);

    // Reset while an NMI request is outstanding.
    I_nmi_n = 1'b1;
    step(3);
    I_nmi_n = 1'b0;
    step(3);
    poll();
    plp(8'hFF);
    check("pre_rst_req", {6'd0, O_int_req, O_int_nmi}, 8'h03);
    I_push_brk = 1'b1;
    #2;
    I_reset_n = 1'b0;
    #1;
    check("mid_rst_p",    O_p,    8'h24);
    check("mid_rst_push", O_push, 8'h34);
    check("mid_rst_int",  {6'd0, O_int_req, O_int_nmi}, 8'h00);
    I_nmi_n    = 1'b1;
    I_push_brk = 1'b0;
    #2;
    I_reset_n = 1'b1;
    step(1);
    poll();
    check("post_rst_poll", {6'd0, O_int_req, O_int_nmi}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_status.md
# core_status

Processor status (P) register and interrupt-poll stage of the CPU core, directly downstream of the ALU. It commits the ALU's carry/overflow/sign/zero outputs, applies flag instructions and whole-P loads (PLP/RTI), and feeds the live flags back to the ALU flag inputs. It also synchronises the NMI/IRQ pins and makes the per-instruction interrupt decision for the sequencer, including the one-instruction I-flag delay.

## Interface
- P_RESET, 8'h24, P value loaded at reset; bits 5 and 4 are ignored.
- I_clock  in  1  core clock; all state updates on the rising edge.
- I_reset_n  in  1  asynchronous, active-low reset.
- I_ready  in  1  cycle enable; low freezes P, i_mask and poll outputs.
- I_alu_write  in  1  commit the ALU flag outputs into N, V, Z, C.
- I_alu_carry, I_alu_overflow, I_alu_sign, I_alu_zero  in  1 each  flag outputs from the ALU.
- I_p_load  in  1  load P from I_data (PLP, RTI pull).
- I_data  in  8  pulled status byte.
- I_flag_op  in  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED.
- I_set_i  in  1  set I on interrupt or BRK entry.
- I_push_brk  in  1  value driven on bit 4 of O_push.
- I_sync  in  1  opcode-fetch cycle, which is the instruction boundary.
- I_int_ack  in  1  sequencer has started interrupt entry.
- I_nmi_n, I_irq_n  in  1 each  asynchronous, active-low interrupt pins.
- O_p  out  8  stored P, with bit 5 = 1 and bit 4 = 0.
- O_push  out  8  byte to push: stored P, bit 5 = 1, bit 4 = I_push_brk.
- O_carry, O_overflow, O_sign, O_zero  out  1 each  stored C, V, N, Z; these feed the ALU I_carry, I_overflow, I_sign, I_zero.
- O_int_req  out  1  an interrupt must be taken instead of the next opcode.
- O_int_nmi  out  1  the pending request is an NMI; meaningful only when O_int_req = 1.

## Operation
- Stored bits are N, V, D, I, Z and C. Bits 5 and 4 have no storage.
- Write precedence when I_ready = 1, applied per bit:
  - I_p_load overrides I_alu_write and I_flag_op for every bit.
  - Otherwise I_flag_op overrides I_alu_write on any conflicting bit; for example SEC together with an ALU write of C = 0 leaves C = 1.
  - I_set_i forces I = 1 over all other sources.
- O_push and the O_* flag outputs are combinational from the stored bits. They are never bypassed from same-cycle writes.
- i_mask register: copies stored I on each I_ready & I_sync edge. The IRQ decision reads i_mask as it was before that edge. As a result, CLI, SEI and PLP change IRQ masking one instruction late, while O_p changes immediately.
- NMI path:
  - Two-flop synchroniser, then a previous-value flop.
  - A synchronised 1→0 transition sets nmi_pending.
  - A held-low pin yields exactly one edge.
- IRQ path: two-flop synchroniser, level-sensitive; there is no latch.
- Poll, on an I_ready & I_sync edge:
  - O_int_req <= nmi_pending | (irq_sync == 0 & ~i_mask_old).
  - O_int_nmi <= nmi_pending.
- On I_int_ack:
  - O_int_req and O_int_nmi clear.
  - If O_int_nmi = 1, nmi_pending also clears, unless a new NMI edge is detected on the same edge; the new edge wins and pending stays 1.
- Synchronisers, the edge detector and nmi_pending keep running while I_ready = 0. NMI edges during DMA stalls are never lost.

## Timing
- Reset (asynchronous):
  - P = P_RESET, giving O_p = 8'h24 by default.
  - i_mask = 1.
  - Synchroniser and previous-value flops = 1.
  - nmi_pending = 0, O_int_req = 0, O_int_nmi = 0.
  - O_push = 8'h24 | (I_push_brk << 4).
- P write: visible on O_p and the flag outputs after the write edge. The ALU sees the new flags on the following cycle.
- IRQ: pin low before edge k → irq_sync is low after edge k+1, so it is usable at a poll on edge k+2 or later.
- NMI: pin falling before edge k → nmi_pending = 1 after edge k+2.
- Poll result: O_int_req is valid from the cycle after the I_sync edge and held until the next poll or I_int_ack.
- Reset asserted mid-instruction: everything returns to reset values immediately, and a pending NMI is discarded.

## Test plan
- Reset release → O_p = 8'h24, O_int_req = 0. Then a PLP (I_p_load) of I_data = 8'hFF → O_p = 8'hEF; with I_push_brk = 1 → O_push = 8'hFF.
- From O_p = 8'h24: I_alu_write with C = 1, V = 1, N = 0, Z = 1 → O_p = 8'h67. Repeat the same write with I_flag_op = CLC → O_p = 8'h66.
- I_irq_n held low, I = 1:
  - CLI cycle, then I_sync → O_int_req = 0.
  - Next I_sync → O_int_req = 1, O_int_nmi = 0.
  - I_int_ack → 0.
- I_nmi_n driven low and held → O_int_req = 1 and O_int_nmi = 1 at the first poll after 3 edges. After I_int_ack, no further request while the pin stays low. Pin high for 3 cycles, then low again → a new request.
- I_ready = 0 for 10 cycles with I_alu_write, I_flag_op = SEI and an NMI falling edge applied → P unchanged. After I_ready returns to 1, the first I_sync gives O_int_nmi = 1.
- I_int_ack on the same edge a new NMI edge is detected → nmi_pending stays 1, and the next poll gives O_int_req = 1. Reset asserted while pending → all outputs return to reset values.
